mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the pipelined RV32 core: it answers the core's instruction-fetch port and data-memory port. It holds an instruction ROM, a word-addressed data RAM and a small memory-mapped I/O region with a console TX FIFO that drains over a valid/ready stream, plus a free-running timer with a compare interrupt. It sits beside the core at SoC top level. The core's `pc_o`, `out_FU_me`, `mw_o` and `write_data_M` drive this block, and this block drives the core's `instr` and `data_in`.

## Interface
- `IMEM_WORDS`, 1024: instruction ROM depth in 32-bit words (power of 2).
- `DMEM_WORDS`, 1024: data RAM depth in 32-bit words (power of 2).
- `FIFO_DEPTH`, 8: TX FIFO depth in bytes (power of 2, 2..128).
- `IMEM_INIT`, "": hex file for the `$readmemh` ROM image; empty means no preload.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `pc_i` input 32: fetch address.
- `instr_o` output 32: fetched instruction.
- `addr_i` input 32: data address.
- `we_i` input 1: data write enable.
- `wdata_i` input 32: store data.
- `rdata_o` output 32: load data.
- `tx_valid_o` output 1: a console byte is available.
- `tx_data_o` output 8: the console byte.
- `tx_ready_i` input 1: the downstream sink accepts the byte.
- `timer_irq_o` output 1: timer compare interrupt.

## Operation
**Fetch**
- `instr_o = imem[pc_i[IMEM_AW+1:2]]`. Combinational; the index wraps modulo `IMEM_WORDS`; `pc_i[1:0]` is ignored.

**Data accesses**
- Every access is a whole word; `addr_i[1:0]` is ignored. The core has no byte enables.
- Reads are combinational. Writes take effect at the rising edge where `we_i`=1.

**Address map**
- 0x0000_0000 .. 4*DMEM_WORDS-1: data RAM, read/write.
- 0x1000_0000 TXDATA: a write pushes `wdata_i[7:0]`; a read returns 0.
- 0x1000_0004 TXSTAT, read-only fields:
  - bit0: full.
  - bit1: empty.
  - bit2: overflow (sticky).
  - bits[15:8]: count.
  - Any write to TXSTAT clears overflow.
- 0x1000_0008 MTIME: read/write.
- 0x1000_000C MTIMECMP: read/write.
- Any other address: reads 0, writes are ignored.

**TX FIFO**
- A push while full is dropped and sets overflow. This holds even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO: both occur and count is unchanged.
- Push into an empty FIFO: `tx_valid_o` rises on the next cycle. There is no same-cycle bypass.
- `tx_valid_o` = !empty. `tx_data_o` = head byte, or 0 when empty.
- A transfer occurs on a rising edge with `tx_valid_o` & `tx_ready_i`.
- Once asserted, `tx_valid_o` and `tx_data_o` stay stable until a transfer occurs.
- Read/write pointers wrap modulo `FIFO_DEPTH`.

**Timer**
- MTIME increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
- A write to MTIME loads `wdata_i` in place of the increment for that cycle.
- Reset values: MTIMECMP = 0xFFFF_FFFF, MTIME = 0.
- `timer_irq_o` is registered: `timer_irq_o` <= (MTIME >= MTIMECMP), unsigned, using the current register values.
- Writing MTIMECMP above MTIME drops the IRQ one cycle after the compare registers update.

## Timing
- Fetch and load latency: 0 cycles (combinational). A store is visible to a load in the next cycle.
- Reset (asynchronous assert; deassert sampled at the next rising edge):
  - Outputs: `tx_valid_o`=0, `tx_data_o`=0, `timer_irq_o`=0.
  - Internal state: FIFO empty, overflow=0, MTIME=0, MTIMECMP=0xFFFF_FFFF.
  - RAM and ROM contents are not reset.
- Reset asserted during a pending TX: the FIFO contents are discarded and `tx_valid_o` falls immediately.
- `rdata_o` and `instr_o` do not depend on reset.

## Configuration
- `MEM_RESP_TIMER_EN` defined: the timer is present as specified above.
- Undefined:
  - MTIME and MTIMECMP read 0 and writes to them are ignored.
  - `timer_irq_o` is tied to 0.
  - No timer registers are synthesized.

## Structure
- Package `mem_resp_pkg` holds:
  - The MMIO base address and register offsets.
  - The TXSTAT bit positions.
  - The RAM-region decode limit helper.
- Sub-module `tx_fifo`: parameterized synchronous FIFO with:
  - Push, pop, full, empty, count and head outputs.
  - Asynchronous active-low reset.
- Top-level logic: address decode, RAM/ROM arrays, the timer and the read mux.

## Test plan
1. Store 0xDEADBEEF to 0x0000_0010, load in the next cycle -> `rdata_o`=0xDEADBEEF. A load from 0x0000_0013 returns the same word.
2. With `tx_ready_i`=0, push bytes 0x41..0x49 (9 writes, depth 8):
   - TXSTAT = 0x0000_0805 (count 8, full, overflow).
   - `tx_data_o`=0x41 and stays stable.
3. Raise `tx_ready_i` -> bytes 0x41..0x48 drain one per cycle, then `tx_valid_o`=0. Writing TXSTAT then reading it -> 0x0000_0002.
4. On a FIFO with count 3, push and pop in the same cycle -> count stays 3 and byte order is preserved.
5. Timer (with the macro):
   - Write MTIMECMP=20 at reset+0 -> `timer_irq_o` rises when MTIME first reaches 20, registered one cycle later.
   - Write MTIME=0xFFFF_FFFE -> MTIME wraps to 0 two cycles later.
6. Set `pc_i`=4*IMEM_WORDS+8 -> `instr_o` equals ROM word 2. Assert `rst_ni` mid-drain -> `tx_valid_o`=0 immediately.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared constants for mem_responder: MMIO map, TXSTAT layout and the RAM-region decode helper.
package mem_resp_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

  localparam logic [3:0] OFF_TXDATA   = 4'h0;
  localparam logic [3:0] OFF_TXSTAT   = 4'h4;
  localparam logic [3:0] OFF_MTIME    = 4'h8;
  localparam logic [3:0] OFF_MTIMECMP = 4'hC;

  typedef enum logic [1:0] {
    REG_TXDATA   = OFF_TXDATA[3:2],
    REG_TXSTAT   = OFF_TXSTAT[3:2],
    REG_MTIME    = OFF_MTIME[3:2],
    REG_MTIMECMP = OFF_MTIMECMP[3:2]
  } mmio_reg_e;

  localparam int TXSTAT_FULL_BIT  = 0;
  localparam int TXSTAT_EMPTY_BIT = 1;
  localparam int TXSTAT_OVF_BIT   = 2;
  localparam int TXSTAT_COUNT_LSB = 8;
  localparam int TXSTAT_COUNT_W   = 8;

  function automatic logic in_ram_region(input logic [31:0] addr, input int unsigned words);
    return addr < (32'(words) << 2);
  endfunction

  // The four MMIO registers fill the whole 16-byte window, so only the upper bits decode.
  function automatic logic in_mmio_region(input logic [31:0] addr);
    return addr[31:4] == MMIO_BASE[31:4];
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with occupancy count; pushes while full and pops while empty are dropped.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = AW + 1
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem[rd_ptr_q];

  // Full is judged on the registered count, so a simultaneous pop does not rescue a push.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the RV32 core: ROM, word RAM, console TX FIFO and optional timer.
// Define MEM_RESP_TIMER_EN to build the MTIME/MTIMECMP timer and its compare interrupt.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int    IMEM_WORDS = 1024,
  parameter int    DMEM_WORDS = 1024,
  parameter int    FIFO_DEPTH = 8,
  parameter string IMEM_INIT  = ""
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        timer_irq_o
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);
  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] imem_mem [IMEM_WORDS];
  logic [31:0] dmem_mem [DMEM_WORDS];

  assign instr_o = imem_mem[pc_i[IMEM_AW+1:2]];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_i[31:IMEM_AW+2], pc_i[1:0]};

  logic      ram_sel, mmio_sel;
  mmio_reg_e reg_sel;
  logic      wr_txdata, wr_txstat;

  assign ram_sel   = in_ram_region(addr_i, DMEM_WORDS);
  assign mmio_sel  = in_mmio_region(addr_i);
  assign reg_sel   = mmio_reg_e'(addr_i[3:2]);
  assign wr_txdata = we_i && mmio_sel && (reg_sel == REG_TXDATA);
  assign wr_txstat = we_i && mmio_sel && (reg_sel == REG_TXSTAT);

  always_ff @(posedge clk) begin
    if (we_i && ram_sel) dmem_mem[addr_i[DMEM_AW+1:2]] <= wdata_i;
  end

  logic               fifo_full, fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic [7:0]         fifo_head;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .push_i  (wr_txdata),
    .data_i  (wdata_i[7:0]),
    .pop_i   (tx_valid_o && tx_ready_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_head;

  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_txstat)                   ovf_d = 1'b0;
    else if (wr_txdata && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  logic [31:0] txstat;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    txstat                   = '0;
    txstat[TXSTAT_FULL_BIT]  = fifo_full;
    txstat[TXSTAT_EMPTY_BIT] = fifo_empty;
    txstat[TXSTAT_OVF_BIT]   = ovf_q;
    txstat[TXSTAT_COUNT_LSB +: TXSTAT_COUNT_W] = TXSTAT_COUNT_W'(fifo_count);
  end

`ifdef MEM_RESP_TIMER_EN
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q;
  logic        wr_mtime, wr_mtimecmp;

  assign wr_mtime    = we_i && mmio_sel && (reg_sel == REG_MTIME);
  assign wr_mtimecmp = we_i && mmio_sel && (reg_sel == REG_MTIMECMP);

  always_comb begin
    mtime_d    = wr_mtime    ? wdata_i : mtime_q + 32'd1;
    mtimecmp_d = wr_mtimecmp ? wdata_i : mtimecmp_q;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign timer_irq_o = irq_q;
`else
  assign timer_irq_o = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    if (ram_sel) begin
      rdata_o = dmem_mem[addr_i[DMEM_AW+1:2]];
    end else if (mmio_sel) begin
      case (reg_sel)
        REG_TXSTAT:   rdata_o = txstat;
`ifdef MEM_RESP_TIMER_EN
        REG_MTIME:    rdata_o = mtime_q;
        REG_MTIMECMP: rdata_o = mtimecmp_q;
`endif
        default:      rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: TX bytes are queued at push time and checked on transfer.
module tb_mem_responder;

  localparam int IMEM_WORDS = 1024;
  localparam int DMEM_WORDS = 1024;
  localparam int FIFO_DEPTH = 8;

  localparam logic [31:0] A_TXDATA   = 32'h1000_0000;
  localparam logic [31:0] A_TXSTAT   = 32'h1000_0004;
  localparam logic [31:0] A_MTIME    = 32'h1000_0008;
  localparam logic [31:0] A_MTIMECMP = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic [31:0] instr_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        timer_irq_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_exp_q [$];

  always #5 clk = ~clk;

  mem_responder #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .IMEM_INIT  ("")
  ) dut (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .pc_i        (pc_i),
    .instr_o     (instr_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .timer_irq_o (timer_irq_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid & ready hold here.
  always @(negedge clk) begin
    #1;
    if (tx_valid_o && tx_ready_i) begin
      if (tx_exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_unexpected: got byte 0x%02h expected no transfer at %0t", tx_data_o, $time);
      end else begin
        check("tx_byte", {24'h0, tx_data_o}, {24'h0, tx_exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Called at a falling edge; returns at the following falling edge with the write committed.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    addr_i  = addr;
    wdata_i = data;
    we_i    = 1'b1;
    @(negedge clk);
    we_i    = 1'b0;
  endtask

  task automatic bus_read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    addr_i = addr;
    we_i   = 1'b0;
    #1;
    check(name, rdata_o, exp);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    if (accepted) tx_exp_q.push_back(b);
    bus_write(A_TXDATA, {24'h0, b});
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    tx_ready_i = v;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!tx_valid_o && tx_exp_q.size() == 0) break;
      @(negedge clk);
    end
    #2;
    check("tx_drained_valid", {31'h0, tx_valid_o}, 32'h0);
    check("tx_drained_queue", tx_exp_q.size(), 32'h0);
  endtask

  initial begin
    rst_ni     = 1'b0;
    pc_i       = '0;
    addr_i     = '0;
    we_i       = 1'b0;
    wdata_i    = '0;
    tx_ready_i = 1'b0;
    dut.imem_mem[1] = 32'h0040_0113;
    dut.imem_mem[2] = 32'h00A0_0093;

    #1;
    check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data_o}, 32'h0);
    check("rst_irq", {31'h0, timer_irq_o}, 32'h0);
    bus_read_check("rst_txstat", A_TXSTAT, 32'h0000_0002);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

`ifdef MEM_RESP_TIMER_EN
    bus_read_check("rst_mtimecmp", A_MTIMECMP, 32'hFFFF_FFFF);
    addr_i = '0;
    @(negedge clk);
    // MTIME counted 0->1 on the first edge after release; this write lands on the next edge.
    bus_write(A_MTIMECMP, 32'd20);
    for (int k = 2; k <= 27; k++) begin
      bus_read_check("mtime_count", A_MTIME, k);
      check("irq_vs_mtime", {31'h0, timer_irq_o}, {31'h0, (k >= 21)});
      @(negedge clk);
    end
    bus_write(A_MTIMECMP, 32'd1000);
    bus_read_check("mtimecmp_rd", A_MTIMECMP, 32'd1000);
    check("irq_hold_one", {31'h0, timer_irq_o}, 32'h1);
    @(negedge clk);
    #1;
    check("irq_dropped", {31'h0, timer_irq_o}, 32'h0);
    @(negedge clk);
    bus_write(A_MTIME, 32'hFFFF_FFFE);
    bus_read_check("mtime_load", A_MTIME, 32'hFFFF_FFFE);
    @(negedge clk);
    bus_read_check("mtime_max", A_MTIME, 32'hFFFF_FFFF);
    @(negedge clk);
    bus_read_check("mtime_wrap", A_MTIME, 32'h0);
    @(negedge clk);
`else
    bus_write(A_MTIME, 32'd123);
    bus_write(A_MTIMECMP, 32'd0);
    bus_read_check("mtime_absent", A_MTIME, 32'h0);
    bus_read_check("mtimecmp_absent", A_MTIMECMP, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("irq_absent", {31'h0, timer_irq_o}, 32'h0);
    @(negedge clk);
`endif

    // RAM store/load and region boundary
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read_check("ram_load", 32'h0000_0010, 32'hDEAD_BEEF);
    bus_read_check("ram_load_unaligned", 32'h0000_0013, 32'hDEAD_BEEF);
    @(negedge clk);
    bus_write(32'h0000_0000, 32'h1111_1111);
    bus_write(32'h0000_0FFC, 32'h3333_3333);
    bus_write(32'h0000_1000, 32'h2222_2222);
    bus_read_check("ram_word0", 32'h0000_0000, 32'h1111_1111);
    bus_read_check("ram_last", 32'h0000_0FFC, 32'h3333_3333);
    bus_read_check("unmapped_rd", 32'h0000_1000, 32'h0);
    bus_read_check("unmapped_mmio_hi", 32'h1000_0010, 32'h0);

    // Fill past capacity with the sink stalled
    set_ready(1'b0);
    for (int i = 0; i < 9; i++) push_byte(8'h41 + 8'(i), i < FIFO_DEPTH);
    bus_read_check("txstat_full_ovf", A_TXSTAT, 32'h0000_0805);
    bus_read_check("txdata_rd_zero", A_TXDATA, 32'h0);
    check("stall_valid", {31'h0, tx_valid_o}, 32'h1);
    check("stall_head", {24'h0, tx_data_o}, 32'h41);
    repeat (3) @(negedge clk);
    #1;
    check("stall_head_stable", {24'h0, tx_data_o}, 32'h41);

    // Drain, then clear overflow
    set_ready(1'b1);
    wait_drain(20);
    bus_read_check("txstat_empty_ovf", A_TXSTAT, 32'h0000_0006);
    @(negedge clk);
    bus_write(A_TXSTAT, 32'h0);
    bus_read_check("txstat_cleared", A_TXSTAT, 32'h0000_0002);

    // Simultaneous push and pop at count 3
    set_ready(1'b0);
    push_byte(8'h50, 1'b1);
    push_byte(8'h51, 1'b1);
    push_byte(8'h52, 1'b1);
    bus_read_check("txstat_cnt3", A_TXSTAT, 32'h0000_0300);
    @(negedge clk);
    tx_ready_i = 1'b1;
    tx_exp_q.push_back(8'h53);
    addr_i  = A_TXDATA;
    wdata_i = 32'h53;
    we_i    = 1'b1;
    @(negedge clk);
    we_i       = 1'b0;
    tx_ready_i = 1'b0;
    bus_read_check("txstat_pushpop", A_TXSTAT, 32'h0000_0300);
    check("pushpop_head", {24'h0, tx_data_o}, 32'h51);
    set_ready(1'b1);
    wait_drain(20);

    // Fetch wrap and ignored offset bits
    pc_i = 32'd4;
    #1;
    check("fetch_w1", instr_o, 32'h0040_0113);
    pc_i = 32'd4 * IMEM_WORDS + 32'd8;
    #1;
    check("fetch_wrap", instr_o, 32'h00A0_0093);
    pc_i = 32'd11;
    #1;
    check("fetch_offset", instr_o, 32'h00A0_0093);

    // Reset in the middle of a drain
    set_ready(1'b0);
    push_byte(8'h60, 1'b1);
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    set_ready(1'b1);
    #2;
    check("pre_reset_valid", {31'h0, tx_valid_o}, 32'h1);
    #1;
    rst_ni = 1'b0;
    tx_exp_q.delete();
    #1;
    check("mid_reset_valid", {31'h0, tx_valid_o}, 32'h0);
    check("mid_reset_data", {24'h0, tx_data_o}, 32'h0);
    bus_read_check("mid_reset_txstat", A_TXSTAT, 32'h0000_0002);
    @(negedge clk);
    rst_ni = 1'b1;
    set_ready(1'b0);
    @(negedge clk);
    #1;
    check("post_reset_valid", {31'h0, tx_valid_o}, 32'h0);
    check("final_queue", tx_exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
